// File: rtl/if_stage_pkg.sv
// Shared defines for the fetch stage: bus widths, enable/stall encodings and
// the fetch FSM state type.
package if_stage_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

  // Bit positions inside the ctrl stall vector that this stage looks at.
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush and bubble clear the slot, IF+ID stall holds
// it, otherwise the current fetch is captured with its alignment check.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);
  logic aligned;
  assign aligned = (pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(ZeroWord);
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (flush || (stall_if == Stop && stall_id == NoStop)) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(ZeroWord);
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (stall_if == NoStop) begin
      id_pc    <= pc;
      id_valid <= ce;
      id_adel  <= ce & ~aligned;
      // A misaligned fetch is turned into a nop; the adel tag carries the fault.
      id_inst  <= (ce && aligned) ? inst : INST_W'(ZeroWord);
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC/FSM, ROM enable, IF/ID register and a
// saturating count of instructions handed to decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = InstAddrBus,
  parameter int          INST_W   = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              ce,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel,
  output logic [31:0]       fetch_count
);
  if_state_e state;
  logic      deliver;
  logic      unused_stall;

  assign unused_stall = ^stall[5:3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IF_IDLE;
      ce    <= ChipDisable;
      pc    <= ADDR_W'(RESET_PC);
    end else begin
      case (state)
        IF_IDLE: begin
          state <= IF_RUN;
          ce    <= ChipEnable;
        end
        IF_RUN: begin
          ce <= ChipEnable;
          // A branch arriving during a PC stall is dropped; ctrl re-presents it.
          if (flush)                 pc <= new_pc;
          else if (stall[STALL_PC])  pc <= pc;
          else if (branch_flag_i)    pc <= branch_target_address_i;
          else                       pc <= pc + ADDR_W'(4);
        end
        default: begin
          state <= IF_IDLE;
          ce    <= ChipDisable;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_if (stall[STALL_IF]),
    .stall_id (stall[STALL_ID]),
    .ce       (ce),
    .pc       (pc),
    .inst     (inst_i),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .id_adel  (id_adel)
  );

  // Counts loads that put a real fetch (adel slots included) into IF/ID.
  assign deliver = ce & ~flush & ~stall[STALL_IF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fetch_count <= '0;
    else if (deliver && fetch_count != 32'hFFFF_FFFF)
      fetch_count <= fetch_count + 32'd1;
  end
endmodule
